l15_resp_model: RTL and testbench

L1.5-side responder for the core-to-L1.5 transducer request/response protocol. It accepts one request at a time on the `transducer_l15_*` channel and acknowledges it. It services loads and stores against an internal 64-bit-word memory, then returns the response on the `l15_transducer_*` channel, holding it until `transducer_l15_req_ack`. It stands in for the L1.5 in tile-level benches, so a core-side initiator and transducer run without the real cache and NoC.

---
 rtl/l15_resp_model_if.sv | 56 +++++
 rtl/l15_resp_model.sv | 166 ++++++++++++++++
 tb/tb_l15_resp_model.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l15_resp_model_if.sv
// Core-to-L1.5 transducer request/response channel.
// The master modport is the initiator (transducer) side, the slave modport the L1.5 side.
interface l15_resp_model_if #(
    parameter int unsigned PHY_ADDR_WIDTH   = 40,
    parameter int unsigned L15_AMO_OP_WIDTH = 4
);
    logic                        transducer_l15_val;
    logic [4:0]                  transducer_l15_rqtype;
    logic [2:0]                  transducer_l15_size;
    logic [PHY_ADDR_WIDTH-1:0]   transducer_l15_address;
    logic [63:0]                 transducer_l15_data;
    logic [L15_AMO_OP_WIDTH-1:0] transducer_l15_amo_op;
    logic                        transducer_l15_nc;
    logic                        transducer_l15_req_ack;

    logic                        l15_transducer_ack;
    logic                        l15_transducer_header_ack;
    logic                        l15_transducer_val;
    logic [3:0]                  l15_transducer_returntype;
    logic [63:0]                 l15_transducer_data_0;
    logic [63:0]                 l15_transducer_data_1;

    modport master (
        output transducer_l15_val,
        output transducer_l15_rqtype,
        output transducer_l15_size,
        output transducer_l15_address,
        output transducer_l15_data,
        output transducer_l15_amo_op,
        output transducer_l15_nc,
        output transducer_l15_req_ack,
        input  l15_transducer_ack,
        input  l15_transducer_header_ack,
        input  l15_transducer_val,
        input  l15_transducer_returntype,
        input  l15_transducer_data_0,
        input  l15_transducer_data_1
    );

    modport slave (
        input  transducer_l15_val,
        input  transducer_l15_rqtype,
        input  transducer_l15_size,
        input  transducer_l15_address,
        input  transducer_l15_data,
        input  transducer_l15_amo_op,
        input  transducer_l15_nc,
        input  transducer_l15_req_ack,
        output l15_transducer_ack,
        output l15_transducer_header_ack,
        output l15_transducer_val,
        output l15_transducer_returntype,
        output l15_transducer_data_0,
        output l15_transducer_data_1
    );
endinterface

// File: rtl/l15_resp_model.sv
// L1.5 stand-in responder: accepts one request at a time, services loads/stores against a
// private 64-bit-word memory and returns the response after a fixed latency.
module l15_resp_model #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned LATENCY   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    l15_resp_model_if.slave    bus,
    output logic               err,
    output logic [15:0]        load_cnt,
    output logic [15:0]        store_cnt
);
    localparam int unsigned IdxW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {StIdle, StAck, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [4:0]      rqtype_q, rqtype_d;
    logic [2:0]      size_q, size_d;
    logic [IdxW+2:0] addr_q, addr_d;
    logic [63:0]     wdata_q, wdata_d;
    logic [7:0]      lat_cnt_q, lat_cnt_d;
    logic [3:0]      resp_type_q, resp_type_d;
    logic [63:0]     resp_data_q, resp_data_d;
    logic            err_q, err_d;
    logic [15:0]     load_cnt_q, load_cnt_d;
    logic [15:0]     store_cnt_q, store_cnt_d;

    // Deliberately not reset: contents must survive rst_n.
    logic [63:0]     mem_q [MEM_DEPTH];

    logic            is_load, is_store, supported, wr_en;
    logic [IdxW-1:0] word_idx;
    logic [7:0]      byte_en;

    assign is_load   = (rqtype_q == 5'd0);
    assign is_store  = (rqtype_q == 5'd1);
    assign supported = (is_load || is_store) && !size_q[2];
    assign word_idx  = addr_q[IdxW+2:3];
    assign wr_en     = (state_q == StAck) && is_store && supported;

    // byte_en[b] selects big-endian lane b, i.e. bits [63-8b -: 8]
    always_comb begin
        byte_en = '0;
        case (size_q)
            3'd0:    byte_en[addr_q[2:0]] = 1'b1;
            3'd1:    byte_en[{addr_q[2:1], 1'b0} +: 2] = 2'b11;
            3'd2:    byte_en[{addr_q[2], 2'b00} +: 4] = 4'hf;
            3'd3:    byte_en = 8'hff;
            default: byte_en = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (wr_en && byte_en[b]) begin
                mem_q[word_idx][63-8*b -: 8] <= wdata_q[63-8*b -: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rqtype_d    = rqtype_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lat_cnt_d   = lat_cnt_q;
        resp_type_d = resp_type_q;
        resp_data_d = resp_data_q;
        err_d       = err_q;
        load_cnt_d  = load_cnt_q;
        store_cnt_d = store_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (bus.transducer_l15_val) begin
                    rqtype_d = bus.transducer_l15_rqtype;
                    size_d   = bus.transducer_l15_size;
                    addr_d   = bus.transducer_l15_address[IdxW+2:0];
                    wdata_d  = bus.transducer_l15_data;
                    state_d  = StAck;
                end
            end
            StAck: begin
                if (is_load && supported) begin
                    resp_type_d = 4'd0;
                    resp_data_d = mem_q[word_idx];
                end else begin
                    // Stores and unsupported requests both answer with ST_ACK.
                    resp_type_d = 4'd4;
                    resp_data_d = '0;
                end
                if (!supported) begin
                    err_d = 1'b1;
                end
                if (LATENCY > 0) begin
                    lat_cnt_d = 8'(LATENCY);
                    state_d   = StWait;
                end else begin
                    state_d   = StResp;
                end
            end
            StWait: begin
                if (lat_cnt_q <= 8'd1) begin
                    lat_cnt_d = '0;
                    state_d   = StResp;
                end else begin
                    lat_cnt_d = lat_cnt_q - 8'd1;
                end
            end
            StResp: begin
                if (bus.transducer_l15_req_ack) begin
                    state_d = StIdle;
                    if (supported && is_load) begin
                        load_cnt_d = load_cnt_q + 16'd1;
                    end
                    if (supported && is_store) begin
                        store_cnt_d = store_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rqtype_q    <= '0;
            size_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lat_cnt_q   <= '0;
            resp_type_q <= '0;
            resp_data_q <= '0;
            err_q       <= 1'b0;
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rqtype_q    <= rqtype_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lat_cnt_q   <= lat_cnt_d;
            resp_type_q <= resp_type_d;
            resp_data_q <= resp_data_d;
            err_q       <= err_d;
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    assign bus.l15_transducer_ack        = (state_q == StAck);
    assign bus.l15_transducer_header_ack = (state_q == StAck);
    assign bus.l15_transducer_val        = (state_q == StResp);
    assign bus.l15_transducer_returntype = resp_type_q;
    assign bus.l15_transducer_data_0     = resp_data_q;
    assign bus.l15_transducer_data_1     = resp_data_q;

    assign err       = err_q;
    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;
endmodule

// File: tb/tb_l15_resp_model.sv
// Bench for l15_resp_model: directed vector table, timing/busy/reset sequences and a
// randomized run against a byte-addressed reference memory.
module tb_l15_resp_model;
    localparam int unsigned Depth    = 256;
    localparam int unsigned MemBytes = Depth * 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        err, err0;
    logic [15:0] load_cnt, store_cnt, load_cnt0, store_cnt0;

    always #5 clk = ~clk;

    l15_resp_model_if bus ();
    l15_resp_model_if bus0 ();

    l15_resp_model #(.MEM_DEPTH(Depth), .LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .err(err), .load_cnt(load_cnt), .store_cnt(store_cnt)
    );

    l15_resp_model #(.MEM_DEPTH(Depth), .LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .err(err0), .load_cnt(load_cnt0), .store_cnt(store_cnt0)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: flat byte array, byte address modulo memory size.
    logic [7:0] ref_bytes [MemBytes];
    int         m_loads  = 0;
    int         m_stores = 0;
    bit         m_err    = 1'b0;

    typedef struct {
        logic [4:0]  rq;
        logic [2:0]  sz;
        logic [39:0] addr;
        logic [63:0] wd;
        int          hold;
        logic [3:0]  exp_rt;
        logic [63:0] exp_d;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_xact(input logic [4:0] rq, input logic [2:0] sz,
                                       input logic [39:0] a, input logic [63:0] wd,
                                       output logic [3:0] rt, output logic [63:0] rd);
        int unsigned ba, word, off, len, start;
        ba    = 32'(a % 40'(MemBytes));
        word  = ba - ba % 8;
        off   = ba % 8;
        rt    = 4'd4;
        rd    = '0;
        if (!((rq == 5'd0 || rq == 5'd1) && sz < 3'd4)) begin
            m_err = 1'b1;
        end else if (rq == 5'd1) begin
            len   = 1 << sz;
            start = off - off % len;
            for (int unsigned i = 0; i < len; i++) begin
                ref_bytes[word + start + i] = wd[63 - 8 * (start + i) -: 8];
            end
            m_stores++;
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                rd = {rd[55:0], ref_bytes[word + i]};
            end
            rt = 4'd0;
            m_loads++;
        end
    endfunction

    task automatic drive_req(input bit which, input logic v, input logic [4:0] rq,
                             input logic [2:0] sz, input logic [39:0] a, input logic [63:0] d);
        if (which) begin
            bus0.transducer_l15_val     = v;
            bus0.transducer_l15_rqtype  = rq;
            bus0.transducer_l15_size    = sz;
            bus0.transducer_l15_address = a;
            bus0.transducer_l15_data    = d;
        end else begin
            bus.transducer_l15_val      = v;
            bus.transducer_l15_rqtype   = rq;
            bus.transducer_l15_size     = sz;
            bus.transducer_l15_address  = a;
            bus.transducer_l15_data     = d;
        end
    endtask

    task automatic drive_rack(input bit which, input logic v);
        if (which) bus0.transducer_l15_req_ack = v;
        else       bus.transducer_l15_req_ack  = v;
    endtask

    function automatic logic s_ack(input bit which);
        return which ? bus0.l15_transducer_ack : bus.l15_transducer_ack;
    endfunction

    function automatic logic s_hack(input bit which);
        return which ? bus0.l15_transducer_header_ack : bus.l15_transducer_header_ack;
    endfunction

    function automatic logic s_val(input bit which);
        return which ? bus0.l15_transducer_val : bus.l15_transducer_val;
    endfunction

    // Waits (bounded) at negedges for ack (want_val=0) or response val (want_val=1).
    task automatic wait_sig(input bit which, input bit want_val, input int limit);
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (want_val ? s_val(which) : s_ack(which)) break;
        end
    endtask

    task automatic xact(input logic [4:0] rq, input logic [2:0] sz, input logic [39:0] a,
                        input logic [63:0] wd, input int hold,
                        output logic [3:0] rt, output logic [63:0] d0, output logic [63:0] d1);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, rq, sz, a, wd);
        wait_sig(1'b0, 1'b0, 20);
        check("xact_ack", bus.l15_transducer_ack, 1);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 5'd0, 3'd0, '0, '0);
        wait_sig(1'b0, 1'b1, 300);
        check("xact_val", bus.l15_transducer_val, 1);
        rt = bus.l15_transducer_returntype;
        d0 = bus.l15_transducer_data_0;
        d1 = bus.l15_transducer_data_1;
        repeat (hold) begin
            @(negedge clk);
            check("hold_val", bus.l15_transducer_val, 1);
            check("hold_type", bus.l15_transducer_returntype, rt);
            check("hold_data", bus.l15_transducer_data_0, d0);
        end
        drive_rack(1'b0, 1'b1);
        @(posedge clk); #1;
        drive_rack(1'b0, 1'b0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ack"}, bus.l15_transducer_ack, 0);
        check({tag, "_hack"}, bus.l15_transducer_header_ack, 0);
        check({tag, "_val"}, bus.l15_transducer_val, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_rtype"}, bus.l15_transducer_returntype, 0);
        check({tag, "_data0"}, bus.l15_transducer_data_0, 0);
        check({tag, "_data1"}, bus.l15_transducer_data_1, 0);
        check({tag, "_lcnt"}, load_cnt, 0);
        check({tag, "_scnt"}, store_cnt, 0);
    endtask

    // req_ack held high; records ack/header_ack/val for 8 cycles from request cycle T.
    task automatic lat_test(input bit which, input logic [7:0] exp_val, input string name);
        logic [7:0] ack_h, hack_h, val_h;
        logic [3:0]  rt;
        logic [63:0] rd;
        ack_h = '0; hack_h = '0; val_h = '0;
        @(posedge clk); #1;
        drive_rack(which, 1'b1);
        drive_req(which, 1'b1, 5'd0, 3'd3, 40'h40, '0);
        if (!which) model_xact(5'd0, 3'd3, 40'h40, '0, rt, rd);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            ack_h[k]  = s_ack(which);
            hack_h[k] = s_hack(which);
            val_h[k]  = s_val(which);
            @(posedge clk); #1;
            if (k == 1) drive_req(which, 1'b0, 5'd0, 3'd0, '0, '0);
        end
        drive_rack(which, 1'b0);
        check({name, "_ack"}, ack_h, 8'b0000_0010);
        check({name, "_hack"}, hack_h, 8'b0000_0010);
        check({name, "_val"}, val_h, exp_val);
    endtask

    task automatic reset_in_wait(input logic [4:0] rq, input logic [39:0] a,
                                 input logic [63:0] d, input string name);
        logic [3:0]  rt;
        logic [63:0] rd;
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, rq, 3'd3, a, d);
        wait_sig(1'b0, 1'b0, 20);
        check({name, "_ack"}, bus.l15_transducer_ack, 1);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 5'd0, 3'd0, '0, '0);
        @(negedge clk);
        check({name, "_in_wait"}, bus.l15_transducer_val, 0);
        model_xact(rq, 3'd3, a, d, rt, rd);
        rst_n = 1'b0;
        #1;
        check_reset(name);
        m_loads = 0; m_stores = 0; m_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  rt, mrt, r_rt;
        logic [63:0] d0, d1, md, r_d;
        logic [39:0] a;
        logic [4:0]  rq;
        logic [2:0]  sz;
        int          acks_seen;
        logic [15:0] lc_before, sc_before;

        tbl[0] = '{5'd1, 3'd3, 40'h40, 64'h0123456789ABCDEF, 0, 4'd4, 64'h0};
        tbl[1] = '{5'd0, 3'd3, 40'h40, 64'h0, 1, 4'd0, 64'h0123456789ABCDEF};
        tbl[2] = '{5'd1, 3'd0, 40'h43, 64'hAAAAAAAAAAAAAAAA, 2, 4'd4, 64'h0};
        tbl[3] = '{5'd0, 3'd3, 40'h40, 64'h0, 0, 4'd0, 64'h012345AA89ABCDEF};
        tbl[4] = '{5'd1, 3'd1, 40'h45, 64'hBEEFBEEFBEEFBEEF, 0, 4'd4, 64'h0};
        tbl[5] = '{5'd0, 3'd2, 40'h41, 64'h0, 3, 4'd0, 64'h012345AABEEFCDEF};
        tbl[6] = '{5'd1, 3'd2, 40'h47, 64'h1122334455667788, 1, 4'd4, 64'h0};
        tbl[7] = '{5'd0, 3'd0, 40'hAB00000840, 64'h0, 0, 4'd0, 64'h012345AA55667788};

        drive_req(1'b0, 1'b0, 5'd0, 3'd0, '0, '0);
        drive_req(1'b1, 1'b0, 5'd0, 3'd0, '0, '0);
        drive_rack(1'b0, 1'b0);
        drive_rack(1'b1, 1'b0);
        bus.transducer_l15_amo_op  = '0;
        bus.transducer_l15_nc      = 1'b0;
        bus0.transducer_l15_amo_op = '0;
        bus0.transducer_l15_nc     = 1'b0;

        #1 rst_n = 1'b0;
        #1 check_reset("rst0");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            xact(tbl[i].rq, tbl[i].sz, tbl[i].addr, tbl[i].wd, tbl[i].hold, rt, d0, d1);
            model_xact(tbl[i].rq, tbl[i].sz, tbl[i].addr, tbl[i].wd, mrt, md);
            check($sformatf("vec%0d_rtype", i), rt, tbl[i].exp_rt);
            check($sformatf("vec%0d_data0", i), d0, tbl[i].exp_d);
            check($sformatf("vec%0d_data1", i), d1, tbl[i].exp_d);
        end
        check("tbl_scnt", store_cnt, 16'(m_stores));
        check("tbl_lcnt", load_cnt, 16'(m_loads));
        check("tbl_err", err, 0);

        lat_test(1'b0, 8'b0001_0000, "lat2");
        lat_test(1'b1, 8'b0000_0100, "lat0");

        // Backpressure and busy: load held in RESP, second request waits for IDLE.
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 5'd0, 3'd3, 40'h40, '0);
        model_xact(5'd0, 3'd3, 40'h40, '0, mrt, md);
        wait_sig(1'b0, 1'b0, 20);
        check("busy_first_ack", bus.l15_transducer_ack, 1);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 5'd1, 3'd3, 40'hA0, 64'hFEEDFACE0BADF00D);
        acks_seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.l15_transducer_ack) acks_seen++;
            if (bus.l15_transducer_val) break;
        end
        check("busy_no_ack", acks_seen, 0);
        check("busy_resp_val", bus.l15_transducer_val, 1);
        r_rt = bus.l15_transducer_returntype;
        r_d  = bus.l15_transducer_data_0;
        check("busy_rtype", r_rt, mrt);
        check("busy_data", r_d, md);
        repeat (5) begin
            @(negedge clk);
            check("bp_val", bus.l15_transducer_val, 1);
            check("bp_ack", bus.l15_transducer_ack, 0);
            check("bp_rtype", bus.l15_transducer_returntype, mrt);
            check("bp_data0", bus.l15_transducer_data_0, md);
            check("bp_data1", bus.l15_transducer_data_1, md);
        end
        drive_rack(1'b0, 1'b1);
        @(posedge clk); #1;
        drive_rack(1'b0, 1'b0);
        @(negedge clk);
        check("idle_val", bus.l15_transducer_val, 0);
        check("idle_ack", bus.l15_transducer_ack, 0);
        @(negedge clk);
        check("second_ack", bus.l15_transducer_ack, 1);
        model_xact(5'd1, 3'd3, 40'hA0, 64'hFEEDFACE0BADF00D, mrt, md);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 5'd0, 3'd0, '0, '0);
        wait_sig(1'b0, 1'b1, 20);
        check("second_val", bus.l15_transducer_val, 1);
        check("second_rtype", bus.l15_transducer_returntype, 4);
        check("second_data", bus.l15_transducer_data_0, 0);
        drive_rack(1'b0, 1'b1);
        @(posedge clk); #1;
        drive_rack(1'b0, 1'b0);
        check("busy_lcnt", load_cnt, 16'(m_loads));
        check("busy_scnt", store_cnt, 16'(m_stores));

        // Unsupported requests: acked, ST_ACK with zero data, sticky err, no side effects.
        check("pre_unsup_err", err, 0);
        lc_before = load_cnt;
        sc_before = store_cnt;
        xact(5'd6, 3'd3, 40'h40, '1, 1, rt, d0, d1);
        model_xact(5'd6, 3'd3, 40'h40, '1, mrt, md);
        check("unsup_rtype", rt, 4);
        check("unsup_data", d0, 0);
        check("unsup_err", err, 1);
        xact(5'd1, 3'd4, 40'h40, '1, 0, rt, d0, d1);
        model_xact(5'd1, 3'd4, 40'h40, '1, mrt, md);
        check("unsup_sz_rtype", rt, 4);
        check("unsup_lcnt", load_cnt, lc_before);
        check("unsup_scnt", store_cnt, sc_before);
        xact(5'd0, 3'd3, 40'h40, '0, 0, rt, d0, d1);
        model_xact(5'd0, 3'd3, 40'h40, '0, mrt, md);
        check("unsup_mem", d0, 64'h012345AA55667788);
        check("unsup_err_sticky", err, 1);

        // Reset in WAIT: outputs clear at once, memory keeps its contents.
        reset_in_wait(5'd0, 40'h40, '0, "rst_ld");
        reset_in_wait(5'd1, 40'hC0, 64'hCAFEF00D12345678, "rst_st");
        xact(5'd0, 3'd3, 40'h40, '0, 0, rt, d0, d1);
        model_xact(5'd0, 3'd3, 40'h40, '0, mrt, md);
        check("post_rst_40", d0, 64'h012345AA55667788);
        xact(5'd0, 3'd3, 40'hC0, '0, 0, rt, d0, d1);
        model_xact(5'd0, 3'd3, 40'hC0, '0, mrt, md);
        check("post_rst_c0", d0, 64'hCAFEF00D12345678);
        check("post_rst_lcnt", load_cnt, 2);

        // Randomized traffic over 16 aliased words.
        for (int w = 0; w < 16; w++) begin
            a = {$urandom(), $urandom()};
            a[10:0] = 11'(w * 8);
            d0 = {$urandom(), $urandom()};
            xact(5'd1, 3'd3, a, d0, 0, rt, d1, md);
            model_xact(5'd1, 3'd3, a, d0, mrt, md);
        end
        for (int n = 0; n < 150; n++) begin
            a = {$urandom(), $urandom()};
            a[10:3] = 8'($urandom_range(0, 15));
            rq = ($urandom_range(0, 15) == 0) ? 5'(2 + $urandom_range(0, 29))
                                              : 5'($urandom_range(0, 1));
            sz = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(4, 7))
                                              : 3'($urandom_range(0, 3));
            md = {$urandom(), $urandom()};
            xact(rq, sz, a, md, $urandom_range(0, 3), rt, d0, d1);
            model_xact(rq, sz, a, md, mrt, md);
            check($sformatf("rnd%0d_rtype", n), rt, mrt);
            check($sformatf("rnd%0d_data0", n), d0, md);
            check($sformatf("rnd%0d_data1", n), d1, md);
        end
        check("final_lcnt", load_cnt, 16'(m_loads));
        check("final_scnt", store_cnt, 16'(m_stores));
        check("final_err", err, m_err);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
